clk_switch_ctrl: RTL and testbench

- Single-clock controller that drives the select input of the glitch-free two-input clock mux.
- Accepts switch requests over a valid/ready handshake and drives a stable registered `sel`.
- Confirms completion against the mux's selected-clock status (`sel_ack`, asynchronous, synchronised internally).
- Enforces a minimum dwell time between switches and reverts the select on timeout.
- Sits in the always-on control domain beside the clock mux.

---
 rtl/clk_switch_ctrl.sv | 131 +++++++++++++
 tb/tb_clk_switch_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: drives the select of a glitch-free two-input clock mux.
// A request is taken over valid/ready in IDLE. WAIT then holds the new select
// until the mux reports that it has switched, or reverts on timeout. DWELL
// holds the select steady before the next request can be taken.
module clk_switch_ctrl #(
   parameter int SYNC_DEPTH = 2,
   parameter int TIMEOUT    = 255,
   parameter int DWELL      = 16,
   parameter int CNT_W      = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_sel,
   output logic req_ready,
   input  logic sel_ack,
   output logic sel,
   output logic busy,
   output logic done,
   output logic timeout_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_DWELL = 2'd2;

   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST   = CNT_W'(DWELL - 1);

   logic [1:0]            state_q, state_d;
   logic                  sel_q, sel_d;
   logic                  prev_sel_q, prev_sel_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  terr_q, terr_d;
   logic [SYNC_DEPTH-1:0] sync_q;
   logic                  ack_s;

   // Bring the asynchronous mux status into the clk domain.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_DEPTH-2:0], sel_ack};
      end
   end

   assign ack_s = sync_q[SYNC_DEPTH-1];

   // Next-state logic for the IDLE -> WAIT -> DWELL -> IDLE sequence.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      sel_d      = sel_q;
      prev_sel_d = prev_sel_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      terr_d     = terr_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               terr_d = 1'b0;
               if (req_sel == sel_q) begin
                  // No-op request: already on the requested clock.
                  done_d = 1'b1;
               end else begin
                  sel_d      = req_sel;
                  prev_sel_d = sel_q;
                  cnt_d      = '0;
                  state_d    = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // Acknowledge is tested first, so it wins on the timeout edge.
            if (ack_s == sel_q) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_DWELL;
            end else if (cnt_q == TIMEOUT_LAST) begin
               sel_d   = prev_sel_q;
               terr_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_DWELL;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DWELL: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers; reset returns to IDLE with clk1 selected.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst) begin
         state_q    <= ST_IDLE;
         sel_q      <= 1'b0;
         prev_sel_q <= 1'b0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         terr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         prev_sel_q <= prev_sel_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         terr_q     <= terr_d;
      end
   end

   assign req_ready   = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign sel         = sel_q;
   assign done        = done_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: random switch requests with a scoreboard of expected
// done pulses and end-of-busy events, computed from the controller's timing rules.
module tb_clk_switch_ctrl;

   localparam int SYNC_DEPTH = 2;
   localparam int TIMEOUT    = 255;
   localparam int DWELL      = 16;
   localparam int CNT_W      = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic req_valid = 1'b0;
   logic req_sel = 1'b0;
   logic sel_ack = 1'b0;
   logic req_ready, sel, busy, done, timeout_err;

   clk_switch_ctrl #(
      .SYNC_DEPTH(SYNC_DEPTH), .TIMEOUT(TIMEOUT), .DWELL(DWELL), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
      .req_ready(req_ready), .sel_ack(sel_ack), .sel(sel), .busy(busy),
      .done(done), .timeout_err(timeout_err)
   );

   // Posedge k at time 10k+5; the negedge at 10(k+1) observes "cycle k+1".
   always #5 clk = ~clk;

   typedef enum int {EV_DONE = 0, EV_END = 1} ev_e;
   typedef struct {
      ev_e  kind;
      int   cyc;
      logic sel;
      logic terr;
   } ev_t;

   ev_t  exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   bit   mon_en  = 1'b0;
   logic model_sel = 1'b0;
   logic prev_done = 1'b0;
   logic prev_busy = 1'b0;

   function automatic int now_cyc();
      return int'($time / 10);
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, now_cyc());
   endtask

   // Monitor: pops an expected event whenever the DUT pulses done or drops busy.
   always @(negedge clk) begin : monitor
      ev_t e;
      if (mon_en) begin
         if (done) begin
            check("done_not_back_to_back", prev_done, 0);
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_done: done=1 with no expected event (cycle %0d)", now_cyc());
            end else begin
               e = exp_q.pop_front();
               check("done_event_kind", int'(EV_DONE), int'(e.kind));
               check("done_cycle", now_cyc(), e.cyc);
               check("done_sel", sel, e.sel);
               check("done_terr", timeout_err, e.terr);
            end
         end
         if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_end: busy fell with no expected event (cycle %0d)", now_cyc());
            end else begin
               e = exp_q.pop_front();
               check("end_event_kind", int'(EV_END), int'(e.kind));
               check("end_cycle", now_cyc(), e.cyc);
               check("end_sel", sel, e.sel);
               check("end_terr", timeout_err, e.terr);
               check("end_ready", req_ready, 1);
            end
         end
      end
      prev_done = done;
      prev_busy = busy;
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_total++;
         $display("FAIL wait_ready: req_ready stayed 0, required 1 (cycle %0d)", now_cyc());
      end
   endtask

   // One request. noop=1 asks for the current clock. Otherwise the mux reports
   // the switch d cycles after the accept edge (d<=0: it never does).
   task automatic do_txn(input bit noop, input int d);
      bit   ok;
      bit   succ;
      int   a;
      int   e;
      int   end_cyc;
      logic old_sel;
      logic new_sel;
      wait_ready(ok);
      if (!ok) return;
      old_sel   = model_sel;
      new_sel   = noop ? old_sel : ~old_sel;
      req_valid = 1'b1;
      req_sel   = new_sel;
      @(posedge clk);
      a = now_cyc();
      // Success iff the synchronised acknowledge is seen by the timeout edge.
      succ    = !noop && (d > 0) && (d + SYNC_DEPTH <= TIMEOUT);
      e       = a + d + SYNC_DEPTH;
      end_cyc = succ ? e + DWELL + 1 : a + TIMEOUT + DWELL + 1;
      if (noop) begin
         exp_q.push_back('{EV_DONE, a + 1, old_sel, 1'b0});
      end else if (succ) begin
         exp_q.push_back('{EV_DONE, e + 1, new_sel, 1'b0});
         exp_q.push_back('{EV_END, end_cyc, new_sel, 1'b0});
      end else begin
         exp_q.push_back('{EV_END, end_cyc, old_sel, 1'b1});
      end
      @(negedge clk);
      check("accept_sel", sel, new_sel);
      check("accept_terr_clear", timeout_err, 0);
      if (noop) begin
         req_valid = 1'b0;
         check("noop_not_busy", busy, 0);
      end else begin
         check("wait_not_ready", req_ready, 0);
         // Requests offered while busy must be ignored.
         req_valid = 1'($urandom_range(0, 1));
         req_sel   = 1'($urandom_range(0, 1));
         for (int c = a + 1; c < end_cyc; c++) begin
            if (c == a + 4) req_valid = 1'b0;
            if (c == a + 3) check("wait_sel_held", sel, new_sel);
            if (d > 0 && c == a + d) sel_ack = new_sel;
            if (succ) begin
               if (c >= e + 1 && c <= e + 8) sel_ack = 1'($urandom_range(0, 1));
               if (c == e + 9) sel_ack = new_sel;
               if (c == e + 6) begin
                  check("dwell_sel_held", sel, new_sel);
                  check("dwell_no_done", done, 0);
               end
            end else begin
               if (d > 0 && c == a + TIMEOUT + 2) sel_ack = old_sel;
               if (c == a + TIMEOUT + 1) begin
                  check("abort_sel_reverted", sel, old_sel);
                  check("abort_terr_set", timeout_err, 1);
               end
            end
            @(negedge clk);
         end
      end
      model_sel = succ ? new_sel : old_sel;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      // Reset held with a request pending: nothing may move.
      rst       = 1'b0;
      req_valid = 1'b1;
      req_sel   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_sel", sel, 0);
      check("reset_ready", req_ready, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_terr", timeout_err, 0);
      rst       = 1'b1;
      req_valid = 1'b0;
      mon_en    = 1'b1;

      do_txn(1'b0, 4);                        // basic 0->1, ack at cycle 4
      do_txn(1'b1, 0);                        // no-op
      do_txn(1'b0, 0);                        // never acknowledged -> abort
      do_txn(1'b0, TIMEOUT - SYNC_DEPTH);     // ack seen exactly on the timeout edge
      do_txn(1'b0, TIMEOUT - SYNC_DEPTH + 1); // ack one cycle too late
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 3) == 0) do_txn(1'b1, 0);
         else do_txn(1'b0, int'($urandom_range(1, 12)));
      end

      wait_ready(ok);
      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      // Reset in the middle of WAIT forces clk1 back at once.
      mon_en = 1'b0;
      if (model_sel) do_txn(1'b0, 3);
      wait_ready(ok);
      req_valid = 1'b1;
      req_sel   = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("midwait_sel", sel, 1);
      repeat (9) @(negedge clk);
      check("midwait_busy_before_reset", busy, 1);
      rst = 1'b0;
      @(negedge clk);
      check("midwait_reset_sel", sel, 0);
      check("midwait_reset_ready", req_ready, 1);
      check("midwait_reset_busy", busy, 0);
      check("midwait_reset_done", done, 0);
      rst = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
